clock_calendar: RTL and testbench



---
 rtl/clock_pkg.sv | 46 ++++
 rtl/clock_calendar_if.sv | 39 +++
 rtl/clock_calendar_date_step.sv | 32 +++
 rtl/clock_calendar.sv | 130 +++++++++++++
 tb/tb_clock_calendar.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared field widths, packed time/date types and calendar helpers for the
// clock_calendar timekeeping core.
package clock_pkg;

  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned DAY_W   = 5;
  localparam int unsigned MONTH_W = 4;
  localparam int unsigned YEAR_W  = 12;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  typedef struct packed {
    logic [DAY_W-1:0]   day;
    logic [MONTH_W-1:0] month;
    logic [YEAR_W-1:0]  year;
  } date_t;

  // Gregorian rule; year 0 is divisible by 400 and therefore leap.
  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    return ((year[1:0] == 2'b00) && ((year % 12'd100) != '0)) ||
           ((year % 12'd400) == '0);
  endfunction

  // Out-of-range months report 31; callers reject those months separately.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic [YEAR_W-1:0]  year);
    logic [DAY_W-1:0] days;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      4'd2:                    days = is_leap(year) ? 5'd29 : 5'd28;
      default:                 days = 5'd31;
    endcase
    return days;
  endfunction

  function automatic logic time_is_valid(input time_t t);
    return (t.hour <= 5'd23) && (t.min <= 6'd59) && (t.sec <= 6'd59);
  endfunction

endpackage

// File: rtl/clock_calendar_if.sv
// Load/readout bundle between clock_calendar and its front ends.
// Alarm signals exist only when CLOCK_ALARM_EN is defined.
interface clock_calendar_if;
  import clock_pkg::*;

  logic  tick_in;
  time_t time_in;
  logic  time_ow;
  date_t date_in;
  logic  date_ow;
  time_t time_out;
  date_t date_out;
  logic  sec_pulse;
  logic  day_pulse;
  logic  load_err;
`ifdef CLOCK_ALARM_EN
  time_t alarm_in;
  logic  alarm_arm;
  logic  alarm;

  modport master (
    output tick_in, time_in, time_ow, date_in, date_ow, alarm_in, alarm_arm,
    input  time_out, date_out, sec_pulse, day_pulse, load_err, alarm
  );
  modport slave (
    input  tick_in, time_in, time_ow, date_in, date_ow, alarm_in, alarm_arm,
    output time_out, date_out, sec_pulse, day_pulse, load_err, alarm
  );
`else
  modport master (
    output tick_in, time_in, time_ow, date_in, date_ow,
    input  time_out, date_out, sec_pulse, day_pulse, load_err
  );
  modport slave (
    input  tick_in, time_in, time_ow, date_in, date_ow,
    output time_out, date_out, sec_pulse, day_pulse, load_err
  );
`endif
endinterface

// File: rtl/clock_calendar_date_step.sv
// Combinational next-date function plus date load validity check; shared by
// the midnight rollover path and the date load path.
module clock_date_step
  import clock_pkg::*;
(
  input  date_t cur_i,
  input  date_t load_i,
  output date_t next_o,
  output logic  load_ok_o
);

  // Next calendar day of cur_i (year wraps 4095 -> 0) and validity of load_i.
  always_comb begin
    next_o = cur_i;
    if (cur_i.day >= days_in_month(cur_i.month, cur_i.year)) begin
      next_o.day = 5'd1;
      if (cur_i.month >= 4'd12) begin
        next_o.month = 4'd1;
        next_o.year  = cur_i.year + 1'b1;
      end else begin
        next_o.month = cur_i.month + 1'b1;
      end
    end else begin
      next_o.day = cur_i.day + 1'b1;
    end

    load_ok_o = (load_i.month >= 4'd1) && (load_i.month <= 4'd12) &&
                (load_i.day >= 5'd1) &&
                (load_i.day <= days_in_month(load_i.month, load_i.year));
  end

endmodule

// File: rtl/clock_calendar.sv
// Time-of-day and Gregorian calendar core with internal one-second prescaler
// or external tick, validated loads and registered status pulses.
// Optional alarm comparator enabled by defining CLOCK_ALARM_EN.
module clock_calendar
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned EXT_TICK   = 0,
  parameter int unsigned RESET_YEAR = 2000
) (
  input  logic clk,
  input  logic rst_n,
  clock_calendar_if.slave bus
);

  localparam int unsigned         PRESC_W   = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_TOP = PRESC_W'(CLK_FREQ - 1);
  localparam logic [YEAR_W-1:0]   RST_YEAR  = YEAR_W'(RESET_YEAR);

  logic [PRESC_W-1:0] presc_q, presc_d;
  time_t              time_q, time_d;
  date_t              date_q, date_d;
  logic               sec_pulse_q, sec_pulse_d;
  logic               day_pulse_q, day_pulse_d;
  logic               load_err_q, load_err_d;
`ifdef CLOCK_ALARM_EN
  logic               alarm_q, alarm_d;
`endif

  date_t date_next;
  logic  date_ok;
  logic  tick;
  logic  time_ok;
  logic  time_ld;
  logic  date_ld;
  logic  carry;

  clock_date_step u_date_step (
    .cur_i     (date_q),
    .load_i    (bus.date_in),
    .next_o    (date_next),
    .load_ok_o (date_ok)
  );

  // Tick source, load arbitration and the sec/min/hour/date cascade.
  always_comb begin
    tick    = (EXT_TICK != 0) ? bus.tick_in : (presc_q == PRESC_TOP);
    time_ok = time_is_valid(bus.time_in);
    time_ld = bus.time_ow && time_ok;
    date_ld = bus.date_ow && date_ok;

    presc_d = presc_q + 1'b1;
    if ((EXT_TICK != 0) || time_ld || tick) begin
      presc_d = '0;
    end

    // A valid time load swallows a coincident tick together with its carry.
    time_d = time_q;
    carry  = 1'b0;
    if (time_ld) begin
      time_d = bus.time_in;
    end else if (tick) begin
      if (time_q.sec == 6'd59) begin
        time_d.sec = '0;
        if (time_q.min == 6'd59) begin
          time_d.min = '0;
          if (time_q.hour == 5'd23) begin
            time_d.hour = '0;
            carry       = 1'b1;
          end else begin
            time_d.hour = time_q.hour + 1'b1;
          end
        end else begin
          time_d.min = time_q.min + 1'b1;
        end
      end else begin
        time_d.sec = time_q.sec + 1'b1;
      end
    end

    date_d = date_q;
    if (date_ld) begin
      date_d = bus.date_in;
    end else if (carry) begin
      date_d = date_next;
    end

    sec_pulse_d = tick && !time_ld;
    day_pulse_d = carry && !date_ld;
    load_err_d  = (bus.time_ow && !time_ok) || (bus.date_ow && !date_ok);
`ifdef CLOCK_ALARM_EN
    alarm_d     = bus.alarm_arm && (alarm_q || (time_d == bus.alarm_in));
`endif
  end

  // State registers; everything returns to the reset image asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      time_q      <= '0;
      date_q      <= '{day: 5'd1, month: 4'd1, year: RST_YEAR};
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef CLOCK_ALARM_EN
      alarm_q     <= 1'b0;
`endif
    end else begin
      presc_q     <= presc_d;
      time_q      <= time_d;
      date_q      <= date_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
      load_err_q  <= load_err_d;
`ifdef CLOCK_ALARM_EN
      alarm_q     <= alarm_d;
`endif
    end
  end

  assign bus.time_out  = time_q;
  assign bus.date_out  = date_q;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.day_pulse = day_pulse_q;
  assign bus.load_err  = load_err_q;
`ifdef CLOCK_ALARM_EN
  assign bus.alarm     = alarm_q;
`endif

endmodule

// File: tb/tb_clock_calendar.sv
// Scoreboard bench for clock_calendar (CLK_FREQ=4, internal tick). The
// reference model keeps time as seconds-of-day and the date as integers.
module tb_clock_calendar;
  import clock_pkg::*;

  localparam int CF = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clock_calendar_if bus();

  clock_calendar #(.CLK_FREQ(CF), .EXT_TICK(0), .RESET_YEAR(2000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] t;
    logic [20:0] d;
    logic        sp;
    logic        dp;
    logic        err;
    logic        al;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stimulus for the next cycle.
  bit s_rst = 1'b0;
  bit s_tow = 1'b0, s_dow = 1'b0, s_arm = 1'b0;
  int s_h, s_m, s_s, s_d, s_mo, s_y;
  int s_alarm_sec = 5;

  // Reference model state.
  int m_sec, m_day, m_mon, m_year, m_presc;
  bit m_alarm;

  function automatic int dim(input int mo, input int y);
    bit leap;
    leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (mo == 2) return leap ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic logic [16:0] pack_time(input int s);
    return {5'(s / 3600), 6'((s / 60) % 60), 6'(s % 60)};
  endfunction

  function automatic logic [20:0] pack_date(input int d, input int mo, input int y);
    return {5'(d), 4'(mo), 12'(y)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive stimulus, advance the model, queue the expectation.
  task automatic step();
    exp_t e;
    bit tick, tok, dok, carry, sp, dp;
    @(posedge clk);
    #2;
    rst_n        = s_rst;
    bus.tick_in  = 1'b0;
    bus.time_ow  = s_tow;
    bus.time_in  = {5'(s_h), 6'(s_m), 6'(s_s)};
    bus.date_ow  = s_dow;
    bus.date_in  = pack_date(s_d, s_mo, s_y);
`ifdef CLOCK_ALARM_EN
    bus.alarm_arm = s_arm;
    bus.alarm_in  = pack_time(s_alarm_sec);
`endif
    sp = 1'b0; dp = 1'b0; carry = 1'b0;
    if (!s_rst) begin
      m_sec = 0; m_day = 1; m_mon = 1; m_year = 2000; m_presc = 0; m_alarm = 1'b0;
      e = '{t: pack_time(0), d: pack_date(1, 1, 2000), sp: 0, dp: 0, err: 0, al: 0};
    end else begin
      tick = (m_presc == CF - 1);
      tok  = (s_h < 24) && (s_m < 60) && (s_s < 60);
      dok  = (s_mo >= 1) && (s_mo <= 12) && (s_d >= 1) && (s_d <= dim(s_mo, s_y));
      if (s_tow && tok) begin
        m_sec   = s_h * 3600 + s_m * 60 + s_s;
        m_presc = 0;
      end else begin
        m_presc = tick ? 0 : m_presc + 1;
        if (tick) begin
          sp    = 1'b1;
          m_sec = m_sec + 1;
          if (m_sec == 86400) begin
            m_sec = 0;
            carry = 1'b1;
          end
        end
      end
      if (s_dow && dok) begin
        m_day = s_d; m_mon = s_mo; m_year = s_y;
      end else if (carry) begin
        dp    = 1'b1;
        m_day = m_day + 1;
        if (m_day > dim(m_mon, m_year)) begin
          m_day = 1;
          m_mon = m_mon + 1;
          if (m_mon > 12) begin
            m_mon  = 1;
            m_year = (m_year + 1) % 4096;
          end
        end
      end
      m_alarm = s_arm && (m_alarm || (m_sec == s_alarm_sec));
      e = '{t: pack_time(m_sec), d: pack_date(m_day, m_mon, m_year), sp: sp, dp: dp,
            err: (s_tow && !tok) || (s_dow && !dok), al: m_alarm};
    end
    sb_q.push_back(e);
    s_tow = 1'b0;
    s_dow = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    s_tow = 1'b1; s_h = h; s_m = m; s_s = s;
  endtask

  task automatic set_date(input int d, input int mo, input int y);
    s_dow = 1'b1; s_d = d; s_mo = mo; s_y = y;
  endtask

  // Idle until the next step lands on an internal tick.
  task automatic to_tick_cycle();
    for (int i = 0; i < 2 * CF && m_presc != CF - 1; i++) step();
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("time_out",  32'(bus.time_out),  32'(e.t));
        chk("date_out",  32'(bus.date_out),  32'(e.d));
        chk("sec_pulse", 32'(bus.sec_pulse), 32'(e.sp));
        chk("day_pulse", 32'(bus.day_pulse), 32'(e.dp));
        chk("load_err",  32'(bus.load_err),  32'(e.err));
`ifdef CLOCK_ALARM_EN
        chk("alarm",     32'(bus.alarm),     32'(e.al));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick_in = 1'b0; bus.time_ow = 1'b0; bus.date_ow = 1'b0;
    bus.time_in = '0;   bus.date_in = '0;
`ifdef CLOCK_ALARM_EN
    bus.alarm_arm = 1'b0; bus.alarm_in = '0;
`endif
    s_h = 0; s_m = 0; s_s = 0; s_d = 1; s_mo = 1; s_y = 2000;

    // Reset, then free run: first sec_pulse CF cycles after release.
    s_rst = 1'b0; idle(3);
    s_rst = 1'b1; idle(10);

    // Leap February rollover, then a century non-leap year.
    set_time(23, 59, 58); set_date(28, 2, 2020); step(); idle(10);
    set_time(23, 59, 58); set_date(28, 2, 2100); step(); idle(10);

    // Year 4095 wraps to 0.
    set_time(23, 59, 59); set_date(31, 12, 4095); step(); idle(6);

    // Rejected and accepted loads.
    set_date(31, 4, 2020); step(); idle(2);
    set_time(24, 0, 0);    step(); idle(2);
    set_date(29, 2, 2000); step(); idle(2);
    set_time(12, 0, 0); set_date(30, 2, 2001); step(); idle(2);
    set_time(12, 60, 0); set_date(15, 7, 2001); step(); idle(2);

    // Time load on a tick cycle at 23:59:59: no carry, prescaler restarts.
    set_time(23, 59, 59); set_date(31, 12, 2021); step();
    to_tick_cycle();
    set_time(10, 20, 30); step(); idle(6);

    // Date load on the midnight carry cycle wins over the rollover.
    set_time(23, 59, 59); set_date(31, 12, 2021); step();
    to_tick_cycle();
    set_date(15, 6, 2022); step(); idle(6);

    // Alarm at 00:00:05 from reset, disarm, then reset while armed.
    s_rst = 1'b0; s_alarm_sec = 5; step();
    s_rst = 1'b1; s_arm = 1'b1; idle(CF * 7);
    s_arm = 1'b0; idle(3);
    s_arm = 1'b1; set_time(0, 0, 5); step(); idle(3);
    s_rst = 1'b0; idle(2);
    s_rst = 1'b1; idle(5);

    // Randomised traffic biased towards month ends and midnight.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0)
          set_time(23, 59, $urandom_range(50, 59));
        else
          set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      end
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 2))
          0: set_date($urandom_range(27, 31), $urandom_range(1, 12), 1900 + 100 * $urandom_range(0, 3));
          1: set_date($urandom_range(28, 31), $urandom_range(1, 12), $urandom_range(0, 4095));
          default: set_date($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 4095));
        endcase
      end
      if ($urandom_range(0, 63) == 0) begin
        s_arm = ~s_arm;
        s_alarm_sec = $urandom_range(0, 86399);
      end
      s_rst = ($urandom_range(0, 499) != 0);
      step();
    end
    s_rst = 1'b1;
    idle(4);

    @(posedge clk);
    #5;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
